game_timer: RTL and testbench
=============================

// Module: game_timer
// PURPOSE
//  Per-digit countdown timer for the two-player memory game; one instance per decimal digit.
//  Counts a 4-bit BCD digit down from LOAD_VAL once per timebase tick.
//  Flags zero on Stop and emits a one-cycle borrow (Bor) on the 0->LOAD_VAL wrap so digits cascade.
//  The timebase comes from a shared free-running counter driven into In.
// PARAMETERS
//  IN_W      11  width of the timebase bus In
//  TICK_BIT  0   In bit whose rising edge is one tick (0 = every 2 clocks in sim; ~10 on board)
//  LOAD_VAL  9   preset/wrap value of the digit (0..15; 9 for BCD)
// PORTS
//  Clk   in   1     system clock; all state on rising edge
//  Rst   in   1     asynchronous, active-low reset
//  In    in   IN_W  free-running timebase count
//  Lent  in   1     1 = count enabled; 0 = synchronous preset (load) of the digit
//  Out   out  4     current digit value
//  Bor   out  1     one-cycle borrow pulse on wrap 0 -> LOAD_VAL
//  Stop  out  1     high while Out == 0
// BEHAVIOUR
//  - Reset (Rst=0, async): Out=LOAD_VAL, Bor=0, Stop=0, edge register prev=0.
//  - Tick: tick = In[TICK_BIT] & ~prev; prev <= In[TICK_BIT] every clock (including while Lent=0).
//  - Lent=0: Out<=LOAD_VAL, Bor<=0, Stop<=0; ticks ignored. Lent has priority over tick.
//  - Lent=1, no tick: Out holds; Bor<=0; Stop<=(Out==0).
//  - Lent=1, tick, Out>0: Out<=Out-1; Bor<=0; Stop<=(Out-1==0).
//  - Lent=1, tick, Out==0: Out<=LOAD_VAL, Bor<=1 (one cycle only), Stop<=0.
//  - Latency: Out/Bor/Stop update on the same edge that samples the tick; all outputs registered.
//  - Bor never stays high two consecutive cycles. Out never exceeds LOAD_VAL after reset or load.
//  - Reset mid-count: immediate return to reset values regardless of Clk.
// CONFIGURATION
//  - GAME_TIMER_ONESHOT_EN defined: no wrap. A tick at Out==0 keeps Out=0 and Stop=1.
//    Bor pulses once on the first such tick, then stays 0 until reset or Lent=0.
//    Tracked by an internal sticky "expired" flag, cleared by reset/Lent=0.
//  - Undefined (default): wrapping decade behaviour as described above.
// STRUCTURE
//  - Package game_timer_pkg: DIGIT_W=4, default LOAD_VAL=9, default IN_W=11.
//  - One sub-module tick_edge: rising-edge detector on a single bit.
//    Ports: Clk, Rst, d, pulse.
//  - Remainder: one always block for Out/Bor/Stop.
// TESTING
//  - Reset: Rst=0 -> Out=9, Bor=0, Stop=0 without a clock edge.
//  - Countdown: Lent=1, TICK_BIT=0, In incrementing each clock.
//    -> Out 9,8,...,0 changing every 2 clocks; Stop=1 exactly while Out=0.
//  - Wrap: next tick after Out=0 -> Out=9 and Bor=1 for exactly one clock.
//  - Load: Lent=0 at Out=4 for 9 clocks -> Out=9, Bor=0, Stop=0 throughout.
//    Counting resumes on the first tick after Lent=1.
//  - Reset mid-count: Rst=0 while Out=5 -> Out=9 immediately.
//    After release, counting restarts on the next rising edge of In[0].
//  - ONESHOT_EN: count to 0, two more ticks -> Out stays 0, Stop=1.
//    Bor pulses exactly once; Lent=0 then 1 rearms the flag.

Source files
------------

// File: rtl/game_timer_pkg.sv
// Shared types and defaults for the per-digit countdown timer.
// The action decode is shared by every timer instance built from this slice.
package game_timer_pkg;

  localparam int DIGIT_W          = 4;
  localparam int DEFAULT_LOAD_VAL = 9;
  localparam int DEFAULT_IN_W     = 11;

  typedef logic [DIGIT_W-1:0] digit_t;

  // What the digit does on the coming clock edge.
  typedef enum logic [1:0] {
    ACT_LOAD,       // Lent low: preset the digit
    ACT_HOLD,       // enabled, no tick this cycle
    ACT_DEC,        // tick while the digit is above zero
    ACT_ZERO_TICK   // tick while the digit sits at zero
  } action_t;

  // Lent outranks the tick, and a tick at zero is handled apart from a normal decrement.
  function automatic action_t decode_action(input logic lent,
                                            input logic tick,
                                            input logic is_zero);
    if (!lent)   return ACT_LOAD;
    if (!tick)   return ACT_HOLD;
    if (!is_zero) return ACT_DEC;
    return ACT_ZERO_TICK;
  endfunction

endpackage

// File: rtl/tick_edge.sv
// Rising-edge detector on one bit of the shared timebase.
// The history bit updates every clock, so edges are never stored up while the digit is loading.
module tick_edge (
  input  logic Clk,
  input  logic Rst,
  input  logic d,
  output logic pulse
);

  logic prev;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) prev <= 1'b0;
    else      prev <= d;
  end

  assign pulse = d & ~prev;

endmodule

// File: rtl/game_timer.sv
// One decimal digit of the game countdown; borrows on the 0 -> LOAD_VAL wrap so digits cascade.
// Optional GAME_TIMER_ONESHOT_EN: the digit stops at zero instead of wrapping, and borrows once.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int IN_W     = DEFAULT_IN_W,
  parameter int TICK_BIT = 0,
  parameter int LOAD_VAL = DEFAULT_LOAD_VAL
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [IN_W-1:0] In,
  input  logic            Lent,
  output digit_t          Out,
  output logic            Bor,
  output logic            Stop
);

  localparam digit_t LOAD_DIGIT = digit_t'(LOAD_VAL);

  logic    tick;
  action_t act;

  // Only one timebase bit drives this digit; the rest belong to other digits.
  logic unused_in;
  assign unused_in = ^In;

  tick_edge u_tick_edge (
    .Clk   (Clk),
    .Rst   (Rst),
    .d     (In[TICK_BIT]),
    .pulse (tick)
  );

  assign act = decode_action(Lent, tick, Out == '0);

`ifdef GAME_TIMER_ONESHOT_EN
  // Set by the first tick at zero so the borrow fires only once per run.
  logic expired;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Out  <= LOAD_DIGIT;
      Bor  <= 1'b0;
      Stop <= 1'b0;
`ifdef GAME_TIMER_ONESHOT_EN
      expired <= 1'b0;
`endif
    end else begin
      case (act)
        ACT_LOAD: begin
          Out  <= LOAD_DIGIT;
          Bor  <= 1'b0;
          Stop <= 1'b0;
`ifdef GAME_TIMER_ONESHOT_EN
          expired <= 1'b0;
`endif
        end
        ACT_HOLD: begin
          Bor  <= 1'b0;
          Stop <= (Out == '0);
        end
        ACT_DEC: begin
          Out  <= Out - digit_t'(1);
          Bor  <= 1'b0;
          Stop <= (Out == digit_t'(1));
        end
        ACT_ZERO_TICK: begin
`ifdef GAME_TIMER_ONESHOT_EN
          Bor     <= ~expired;
          Stop    <= 1'b1;
          expired <= 1'b1;
`else
          Out  <= LOAD_DIGIT;
          Bor  <= 1'b1;
          Stop <= 1'b0;
`endif
        end
        default: begin
          Bor  <= 1'b0;
          Stop <= (Out == '0);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: directed countdown/wrap/load/reset scenarios plus random traffic
// checked against a behavioural digit model. Honours GAME_TIMER_ONESHOT_EN when it is defined.
module tb_game_timer;

  localparam int IN_W     = 11;
  localparam int TICK_BIT = 0;
  localparam int LOAD_VAL = 9;

  logic            Clk  = 1'b0;
  logic            Rst  = 1'b1;
  logic            Lent = 1'b0;
  logic [IN_W-1:0] In   = '0;
  logic [3:0]      Out;
  logic            Bor;
  logic            Stop;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural digit: plain integers, updated once per clock from the rules for each case.
  int m_out;
  bit m_bor, m_stop, m_prev, m_expired;

  logic [IN_W-1:0] in_cnt = '0;

  game_timer #(
    .IN_W     (IN_W),
    .TICK_BIT (TICK_BIT),
    .LOAD_VAL (LOAD_VAL)
  ) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .In   (In),
    .Lent (Lent),
    .Out  (Out),
    .Bor  (Bor),
    .Stop (Stop)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic void model_reset();
    m_out     = LOAD_VAL;
    m_bor     = 1'b0;
    m_stop    = 1'b0;
    m_prev    = 1'b0;
    m_expired = 1'b0;
  endfunction

  function automatic void model_step(input bit lent, input bit tb_bit);
    bit tick;
    tick   = tb_bit && !m_prev;
    m_prev = tb_bit;
    if (!lent) begin
      m_out = LOAD_VAL; m_bor = 1'b0; m_stop = 1'b0; m_expired = 1'b0;
    end else if (!tick) begin
      m_bor = 1'b0; m_stop = (m_out == 0);
    end else if (m_out > 0) begin
      m_out = m_out - 1; m_bor = 1'b0; m_stop = (m_out == 0);
    end else begin
`ifdef GAME_TIMER_ONESHOT_EN
      m_bor = !m_expired; m_expired = 1'b1; m_stop = 1'b1;
`else
      m_out = LOAD_VAL; m_bor = 1'b1; m_stop = 1'b0;
`endif
    end
  endfunction

  // Drive at the falling edge, let one rising edge happen, return at the next falling edge.
  task automatic clk_cycle(input bit lent, input logic [IN_W-1:0] in_v);
    Lent = lent;
    In   = in_v;
    @(posedge Clk);
    model_step(lent, in_v[TICK_BIT]);
    @(negedge Clk);
  endtask

  task automatic count_cycle();
    in_cnt = in_cnt + 1'b1;
    clk_cycle(1'b1, in_cnt);
  endtask

  task automatic test_reset();
    #2 Rst = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (Out !== 4'd9) begin
      tests_failed++;
      $display("FAIL reset_out: got %0d, expected 9", Out);
    end
    tests_run++;
    if (Bor !== 1'b0 || Stop !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got bor=%b stop=%b, expected 0 0", Bor, Stop);
    end
    @(negedge Clk);
    Rst = 1'b1;
    clk_cycle(1'b0, '0);
    tests_run++;
    if (Out !== 4'd9 || Bor !== 1'b0 || Stop !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_load: got out=%0d bor=%b stop=%b, expected 9 0 0", Out, Bor, Stop);
    end
  endtask

  // From a loaded digit with In starting at 0: clock n sees In=n, so tick count is (n+1)/2.
  task automatic test_countdown();
    for (int n = 1; n <= 18; n++) begin
      int t;
      logic [3:0] exp_out;
      count_cycle();
      t = (n + 1) / 2;
      exp_out = 4'(9 - t);
      tests_run++;
      if (Out !== exp_out || Bor !== 1'b0 || Stop !== (exp_out == 4'd0)) begin
        tests_failed++;
        $display("FAIL countdown n=%0d: got out=%0d bor=%b stop=%b, expected out=%0d bor=0 stop=%b",
                 n, Out, Bor, Stop, exp_out, exp_out == 4'd0);
      end
    end
  endtask

  task automatic test_wrap();
    int bor_seen;
    bor_seen = 0;
    for (int n = 19; n <= 40; n++) begin
      int t;
      logic [3:0] exp_out;
      logic exp_bor, exp_stop;
      count_cycle();
      t = (n + 1) / 2;
`ifdef GAME_TIMER_ONESHOT_EN
      exp_out  = 4'd0;
      exp_bor  = (n == 19);
      exp_stop = 1'b1;
`else
      exp_out  = (t % 10 == 0) ? 4'd9 : 4'(9 - (t % 10));
      exp_bor  = (n % 2 == 1) && (t % 10 == 0);
      exp_stop = (exp_out == 4'd0);
`endif
      if (Bor === 1'b1) bor_seen++;
      tests_run++;
      if (Out !== exp_out || Bor !== exp_bor || Stop !== exp_stop) begin
        tests_failed++;
        $display("FAIL wrap n=%0d: got out=%0d bor=%b stop=%b, expected out=%0d bor=%b stop=%b",
                 n, Out, Bor, Stop, exp_out, exp_bor, exp_stop);
      end
    end
    tests_run++;
`ifdef GAME_TIMER_ONESHOT_EN
    if (bor_seen != 1) begin
`else
    if (bor_seen != 2) begin
`endif
      tests_failed++;
      $display("FAIL wrap_bor_count: got %0d borrow pulses", bor_seen);
    end
  endtask

  task automatic test_load();
    int guard;
    clk_cycle(1'b0, in_cnt);
    guard = 0;
    while (m_out != 4 && guard < 40) begin
      count_cycle();
      guard++;
    end
    tests_run++;
    if (Out !== 4'd4) begin
      tests_failed++;
      $display("FAIL load_setup: got out=%0d, expected 4 (guard=%0d)", Out, guard);
    end
    for (int i = 0; i < 9; i++) begin
      in_cnt = in_cnt + 1'b1;
      clk_cycle(1'b0, in_cnt);
      tests_run++;
      if (Out !== 4'd9 || Bor !== 1'b0 || Stop !== 1'b0) begin
        tests_failed++;
        $display("FAIL load_hold i=%0d: got out=%0d bor=%b stop=%b, expected 9 0 0", i, Out, Bor, Stop);
      end
    end
    for (int i = 0; i < 6; i++) begin
      count_cycle();
      tests_run++;
      if (Out !== 4'(m_out) || Bor !== m_bor || Stop !== m_stop) begin
        tests_failed++;
        $display("FAIL load_resume i=%0d: got out=%0d bor=%b stop=%b, expected out=%0d bor=%b stop=%b",
                 i, Out, Bor, Stop, m_out, m_bor, m_stop);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (m_out != 5 && guard < 40) begin
      count_cycle();
      guard++;
    end
    tests_run++;
    if (Out !== 4'd5) begin
      tests_failed++;
      $display("FAIL reset_mid_setup: got out=%0d, expected 5", Out);
    end
    #2 Rst = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (Out !== 4'd9 || Bor !== 1'b0 || Stop !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: got out=%0d bor=%b stop=%b, expected 9 0 0", Out, Bor, Stop);
    end
    @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      count_cycle();
      tests_run++;
      if (Out !== 4'(m_out) || Bor !== m_bor || Stop !== m_stop) begin
        tests_failed++;
        $display("FAIL reset_mid_resume i=%0d: got out=%0d bor=%b stop=%b, expected out=%0d bor=%b stop=%b",
                 i, Out, Bor, Stop, m_out, m_bor, m_stop);
      end
    end
  endtask

  // A reload must rearm the borrow: one full run from preset crosses zero exactly once.
  task automatic test_reload_bor();
    int bor_seen;
    bor_seen = 0;
    clk_cycle(1'b0, in_cnt);
    for (int i = 0; i < 25; i++) begin
      count_cycle();
      if (Bor === 1'b1) bor_seen++;
      tests_run++;
      if (Out !== 4'(m_out) || Bor !== m_bor || Stop !== m_stop) begin
        tests_failed++;
        $display("FAIL reload i=%0d: got out=%0d bor=%b stop=%b, expected out=%0d bor=%b stop=%b",
                 i, Out, Bor, Stop, m_out, m_bor, m_stop);
      end
    end
    tests_run++;
    if (bor_seen != 1) begin
      tests_failed++;
      $display("FAIL reload_bor_count: got %0d borrow pulses, expected 1", bor_seen);
    end
  endtask

  task automatic test_random();
    bit prev_bor;
    prev_bor = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bit lent_v;
      logic [IN_W-1:0] in_v;
      if ($urandom_range(0, 99) == 0) begin
        #2 Rst = 1'b0;
        #1;
        model_reset();
        @(negedge Clk);
        Rst = 1'b1;
      end
      lent_v = ($urandom_range(0, 15) != 0);
      in_v   = IN_W'($urandom);
      clk_cycle(lent_v, in_v);
      tests_run++;
      if (Out !== 4'(m_out) || Bor !== m_bor || Stop !== m_stop || (prev_bor && Bor === 1'b1)) begin
        tests_failed++;
        $display("FAIL random i=%0d: got out=%0d bor=%b stop=%b, expected out=%0d bor=%b stop=%b",
                 i, Out, Bor, Stop, m_out, m_bor, m_stop);
      end
      prev_bor = m_bor;
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_wrap();
    test_load();
    test_reset_mid();
    test_reload_bor();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
